io_bus_receiver: RTL and testbench
==================================

# io_bus_receiver

Device-side receiver for the PDP-8/I negative I/O bus. The bus drivers on the processor side assert device select (BMB03–08), the IOP1/IOP2/IOP4 pulses and the AC data lines. This block synchronizes and de-glitches those signals, decodes its own device code, and executes the three IOT pulses:

- IOP1: skip-on-flag
- IOP2: clear flag, clear AC
- IOP4: load AC into a one-entry buffer with a valid/ready handshake to local device logic

It sits between the level-shifted bus inputs and a peripheral's internal logic. Its `skip` and `ac_clear` outputs feed back to the bus driver.

## Interface

Parameters:
- `DEVICE_CODE`, default 6'o40: device select code matched against `bmb`.
- `FILTER`, default 2, minimum 1: consecutive synchronized-high cycles required to qualify an IOP pulse.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `bmb` in 6: device select bits BMB03–08, active-high after level shifting.
- `iop1`, `iop2`, `iop4` in 1 each: IOT pulses, asynchronous to `clk`, active-high.
- `bac` in 12: AC data lines, stable for the whole IOP pulse.
- `dev_flag_set` in 1: one-cycle request from device logic to set the device flag.
- `data` out 12: buffered AC word.
- `data_valid` out 1: `data` holds an unconsumed word.
- `data_ready` in 1: device logic accepts `data`.
- `skip` out 1: skip request to the bus driver.
- `ac_clear` out 1: AC clear request to the bus driver.
- `flag` out 1: device flag.
- `overrun` out 1: sticky; an IOP4 word was lost.

## Operation

- **Synchronization:**
  - `iop1`, `iop2`, `iop4`, `bmb` and `bac` each pass through a 2-flop synchronizer.
  - All decisions use the synchronized copies.
- **Per-pulse qualifier:** three independent instances, one per IOP. States:
  - IDLE, synced pulse low: go to QUAL when synced high. The counter is 0.
  - QUAL: while synced high, increment the counter. When it reaches FILTER, fire the action and go to ACTIVE. If synced low first, return to IDLE with no action (glitch rejected).
  - ACTIVE: wait until synced low, then go to IDLE.
- **Action gating:** an action fires only if synced `bmb` equals `DEVICE_CODE` at the firing edge. Otherwise the qualifier still passes through ACTIVE with no effect.
- **IOP1 action:**
  - If `flag`=1, set `skip`.
  - `skip` clears on the first edge where synced `iop1` is low.
- **IOP2 action:**
  - Clear `flag` and `overrun`.
  - Set `ac_clear`; it clears like `skip`, but tracking `iop2`.
- **IOP4 action:**
  - If `data_valid`=0, or a transfer (`data_valid`&`data_ready`) occurs in the same cycle: load synced `bac` into `data` and set `data_valid`=1.
  - Otherwise keep the old `data` and set `overrun`.
- **Handshake:**
  - A transfer occurs on each edge with `data_valid`&`data_ready`.
  - On a transfer, `data_valid` drops, unless an IOP4 load occurs on the same edge, in which case it stays 1 with the new word.
  - `data` is stable while `data_valid`=1 and no transfer occurs.
- **`flag`:**
  - Set by `dev_flag_set`.
  - If set and IOP2 clear fall on the same edge, the set wins.
- **`overrun`:** if an overrun event and IOP2 clear fall on the same edge, the set wins.

## Timing

- **Reset:** `skip`, `ac_clear`, `flag`, `overrun`, `data_valid` = 0 and `data` = 12'o0000. Synchronizers and counters are cleared and all qualifiers go to IDLE.
- **Reset mid-pulse:** any in-progress action is discarded. A pulse still high after reset release re-qualifies as a new pulse.
- **Latency:** raw pulse first sampled high at edge 0, so its synced copy is high after edge 1. The action registers at edge 1+FILTER; with FILTER=2 that is edge 3.
  - `skip` and `ac_clear` go high after that edge.
  - `skip` and `ac_clear` go low 2 edges after the raw pulse is first sampled low.
- **Glitch rejection:** a raw pulse high for fewer than FILTER consecutive samples produces no action.
- **One action per pulse:** each pulse fires at most one action, regardless of its length.
- **Overlapping pulses:** simultaneous IOP1/IOP2/IOP4 actions on the same edge are all applied.
  - IOP1 samples the pre-edge `flag`, so IOP1+IOP2 on the same edge skips if the flag was set.

## Test plan

- **IOP1 skip:** set `flag` via `dev_flag_set`, `bmb`=6'o40, `iop1` high 6 cycles → `skip`=1 from edge 3 until 2 edges after `iop1` falls. Repeat with `flag`=0 → `skip` never asserts.
- **Select mismatch and glitch:** `bmb`=6'o41 with IOP4, `bac`=12'o7777 → no `data_valid`. Then `bmb`=6'o40 with a 1-cycle `iop4` glitch → no `data_valid`.
- **IOP4 load:** `bac`=12'o5252, IOP4 pulse, `data_ready`=0 → `data`=12'o5252, `data_valid`=1 and held. Pulse `data_ready` → `data_valid`=0.
- **Overrun and simultaneous transfer:**
  - Buffer full (12'o5252), second IOP4 with `bac`=12'o1234 and `data_ready`=0 → `data` stays 12'o5252, `overrun`=1.
  - Repeat with `data_ready`=1 on the action edge → `data`=12'o1234, `data_valid`=1, `overrun` unchanged.
- **IOP2 clear vs. set:**
  - IOP2 → `flag`=0, `overrun`=0, `ac_clear` pulse.
  - IOP2 action coinciding with `dev_flag_set` → `flag`=1.
- **Reset mid-pulse:** assert `rst` during an IOP4 qualification → all outputs 0. After release with `iop4` still high → exactly one load occurs, 1+FILTER edges later.

Source files
------------

// File: rtl/io_bus_receiver.sv
// io_bus_receiver: device-side receiver for the PDP-8/I negative I/O bus.
// Synchronizes and de-glitches the IOP pulses, decodes the device select
// code and executes IOP1 (skip on flag), IOP2 (clear flag / clear AC) and
// IOP4 (load AC into a one-entry buffer drained by a valid/ready handshake).
module io_bus_receiver #(
    parameter logic [5:0] DEVICE_CODE = 6'o40,
    parameter int         FILTER      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  bmb,
    input  logic        iop1,
    input  logic        iop2,
    input  logic        iop4,
    input  logic [11:0] bac,
    input  logic        dev_flag_set,
    output logic [11:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        skip,
    output logic        ac_clear,
    output logic        flag,
    output logic        overrun
);

    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACTIVE
    } qual_state_t;

    // Pulse index: 0 = IOP1, 1 = IOP2, 2 = IOP4
    logic [2:0]    iop_meta, iop_s;
    logic [5:0]    bmb_meta, bmb_s;
    logic [11:0]   bac_meta, bac_s;

    qual_state_t   state [3];
    logic [CW-1:0] cnt   [3];
    logic [2:0]    fire;
    logic [2:0]    act;
    logic          sel;
    logic          load;
    logic          ovr_evt;

    // Two-flop synchronizers for all bus-side inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iop_meta <= '0;
            iop_s    <= '0;
            bmb_meta <= '0;
            bmb_s    <= '0;
            bac_meta <= '0;
            bac_s    <= '0;
        end else begin
            iop_meta <= {iop4, iop2, iop1};
            iop_s    <= iop_meta;
            bmb_meta <= bmb;
            bmb_s    <= bmb_meta;
            bac_meta <= bac;
            bac_s    <= bac_meta;
        end
    end

    // Qualification complete on this edge: the FILTER-th consecutive synced-high sample
    always_comb begin
        fire = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            case (state[i])
                IDLE:    fire[i] = iop_s[i] && (FILTER == 1);
                QUAL:    fire[i] = iop_s[i] && (cnt[i] == CW'(FILTER - 1));
                default: fire[i] = 1'b0;
            endcase
        end
    end

    // Actions only take effect when the synced select matches this device
    always_comb begin
        sel     = (bmb_s == DEVICE_CODE);
        act     = fire & {3{sel}};
        load    = act[2] && (!data_valid || data_ready);
        ovr_evt = act[2] && data_valid && !data_ready;
    end

    // Per-pulse qualifier FSMs: IDLE -> QUAL (count) -> ACTIVE until pulse drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                case (state[i])
                    IDLE: begin
                        if (iop_s[i]) begin
                            if (fire[i]) begin
                                state[i] <= ACTIVE;
                            end else begin
                                state[i] <= QUAL;
                                cnt[i]   <= CW'(1);
                            end
                        end
                    end
                    QUAL: begin
                        if (!iop_s[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (fire[i]) begin
                            state[i] <= ACTIVE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i]   <= cnt[i] + CW'(1);
                        end
                    end
                    ACTIVE: begin
                        if (!iop_s[i]) begin
                            state[i] <= IDLE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Bus feedback: skip / ac_clear held until the synced pulse drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip     <= 1'b0;
            ac_clear <= 1'b0;
        end else begin
            if (act[0] && flag) begin
                skip <= 1'b1;
            end else if (!iop_s[0]) begin
                skip <= 1'b0;
            end

            if (act[1]) begin
                ac_clear <= 1'b1;
            end else if (!iop_s[1]) begin
                ac_clear <= 1'b0;
            end
        end
    end

    // Device flag and sticky overrun: a set on the same edge beats an IOP2 clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (dev_flag_set) begin
                flag <= 1'b1;
            end else if (act[1]) begin
                flag <= 1'b0;
            end

            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (act[1]) begin
                overrun <= 1'b0;
            end
        end
    end

    // One-entry data buffer: IOP4 load may coincide with draining the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (load) begin
                data       <= bac_s;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_receiver.sv
// Self-checking bench for io_bus_receiver (DEVICE_CODE=6'o40, FILTER=2).
// Loaded words are queued when IOP4 is driven and compared on each transfer.
module tb_io_bus_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  bmb = '0;
    logic        iop1 = 1'b0;
    logic        iop2 = 1'b0;
    logic        iop4 = 1'b0;
    logic [11:0] bac = '0;
    logic        dev_flag_set = 1'b0;
    logic [11:0] data;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        skip;
    logic        ac_clear;
    logic        flag;
    logic        overrun;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q [$];

    io_bus_receiver #(
        .DEVICE_CODE (6'o40),
        .FILTER      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bmb          (bmb),
        .iop1         (iop1),
        .iop2         (iop2),
        .iop4         (iop4),
        .bac          (bac),
        .dev_flag_set (dev_flag_set),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .skip         (skip),
        .ac_clear     (ac_clear),
        .flag         (flag),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard: every transfer must deliver the oldest expected word
    always @(negedge clk) begin
        logic [11:0] w;
        if (!rst && data_valid && data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: transfer of data=%o with no word expected", data);
            end else begin
                w = exp_q.pop_front();
                if (data !== w) begin
                    failures++;
                    $display("FAIL sb_data: got %o expected %o", data, w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid: data_valid=%b expected 0", data_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_ticks(3);
        checks++;
        if ({data, data_valid, skip, ac_clear, flag, overrun} !== 17'b0) begin
            failures++;
            $display("FAIL reset_outputs: data=%o valid=%b skip=%b acclr=%b flag=%b ovr=%b expected all 0",
                     data, data_valid, skip, ac_clear, flag, overrun);
        end
        rst = 1'b0;
        bmb = 6'o40;
        wait_ticks(2);
    endtask

    task automatic test_iop1_skip();
        logic exp;
        dev_flag_set = 1'b1;
        tick();
        dev_flag_set = 1'b0;
        checks++;
        if (flag !== 1'b1) begin
            failures++;
            $display("FAIL flag_set: flag=%b expected 1", flag);
        end
        iop1 = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 5) iop1 = 1'b0;
            exp = (e >= 3 && e <= 7);
            checks++;
            if (skip !== exp) begin
                failures++;
                $display("FAIL skip_window e=%0d: skip=%b expected %b", e, skip, exp);
            end
        end
    endtask

    task automatic test_select_glitch();
        bmb = 6'o41;
        bac = 12'o7777;
        iop4 = 1'b1;
        wait_ticks(5);
        iop4 = 1'b0;
        wait_ticks(4);
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL select_mismatch: data_valid=%b expected 0", data_valid);
        end
        bmb = 6'o40;
        wait_ticks(2);
        iop4 = 1'b1;
        tick();
        iop4 = 1'b0;
        wait_ticks(6);
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: data_valid=%b expected 0", data_valid);
        end
    endtask

    task automatic test_iop4_load();
        bac = 12'o5252;
        exp_q.push_back(12'o5252);
        iop4 = 1'b1;
        tick();
        tick();
        iop4 = 1'b0;
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_early: data_valid=%b expected 0 before edge 3", data_valid);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data !== 12'o5252) begin
            failures++;
            $display("FAIL load_edge3: valid=%b data=%o expected 1 5252", data_valid, data);
        end
        wait_ticks(5);
        checks++;
        if (data_valid !== 1'b1 || data !== 12'o5252) begin
            failures++;
            $display("FAIL load_hold: valid=%b data=%o expected 1 5252", data_valid, data);
        end
        drain();
    endtask

    task automatic test_overrun();
        bac = 12'o5252;
        exp_q.push_back(12'o5252);
        iop4 = 1'b1;
        wait_ticks(3);
        iop4 = 1'b0;
        wait_ticks(4);
        bac = 12'o1234;
        iop4 = 1'b1;
        wait_ticks(3);
        iop4 = 1'b0;
        wait_ticks(4);
        checks++;
        if (data !== 12'o5252 || data_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_full: data=%o valid=%b ovr=%b expected 5252 1 1", data, data_valid, overrun);
        end
        exp_q.push_back(12'o1234);
        iop4 = 1'b1;
        wait_ticks(3);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        checks++;
        if (data !== 12'o1234 || data_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_simul: data=%o valid=%b ovr=%b expected 1234 1 1", data, data_valid, overrun);
        end
        iop4 = 1'b0;
        wait_ticks(4);
        drain();
    endtask

    task automatic test_iop2_clear();
        logic exp;
        iop2 = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 5) iop2 = 1'b0;
            exp = (e >= 3 && e <= 7);
            checks++;
            if (ac_clear !== exp) begin
                failures++;
                $display("FAIL acclr_window e=%0d: ac_clear=%b expected %b", e, ac_clear, exp);
            end
        end
        checks++;
        if (flag !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL iop2_clear: flag=%b ovr=%b expected 0 0", flag, overrun);
        end
    endtask

    task automatic test_iop1_noflag();
        iop1 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e == 5) iop1 = 1'b0;
            checks++;
            if (skip !== 1'b0) begin
                failures++;
                $display("FAIL skip_noflag e=%0d: skip=%b expected 0", e, skip);
            end
        end
    endtask

    task automatic test_iop2_vs_set();
        iop2 = 1'b1;
        wait_ticks(3);
        dev_flag_set = 1'b1;
        tick();
        dev_flag_set = 1'b0;
        checks++;
        if (flag !== 1'b1 || ac_clear !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clear: flag=%b acclr=%b expected 1 1", flag, ac_clear);
        end
        iop2 = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_overlap();
        bac = 12'o0123;
        exp_q.push_back(12'o0123);
        iop4 = 1'b1;
        wait_ticks(2);
        iop4 = 1'b0;
        wait_ticks(5);
        bac = 12'o7654;
        {iop1, iop2, iop4} = 3'b111;
        wait_ticks(4);
        checks++;
        if (skip !== 1'b1 || ac_clear !== 1'b1 || flag !== 1'b0 || overrun !== 1'b1 || data !== 12'o0123) begin
            failures++;
            $display("FAIL overlap: skip=%b acclr=%b flag=%b ovr=%b data=%o expected 1 1 0 1 0123",
                     skip, ac_clear, flag, overrun, data);
        end
        {iop1, iop2, iop4} = 3'b000;
        wait_ticks(4);
        checks++;
        if (skip !== 1'b0 || ac_clear !== 1'b0) begin
            failures++;
            $display("FAIL overlap_release: skip=%b acclr=%b expected 0 0", skip, ac_clear);
        end
        drain();
    endtask

    task automatic test_reset_mid_pulse();
        bac = 12'o3333;
        iop4 = 1'b1;
        wait_ticks(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({data, data_valid, skip, ac_clear, flag, overrun} !== 17'b0) begin
            failures++;
            $display("FAIL reset_mid: data=%o valid=%b skip=%b acclr=%b flag=%b ovr=%b expected all 0",
                     data, data_valid, skip, ac_clear, flag, overrun);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(12'o3333);
        wait_ticks(3);
        checks++;
        if (data_valid !== 1'b0) begin
            failures++;
            $display("FAIL requal_early: data_valid=%b expected 0", data_valid);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data !== 12'o3333) begin
            failures++;
            $display("FAIL requal_load: valid=%b data=%o expected 1 3333", data_valid, data);
        end
        wait_ticks(6);
        checks++;
        if (overrun !== 1'b0 || data_valid !== 1'b1) begin
            failures++;
            $display("FAIL one_action: ovr=%b valid=%b expected 0 1", overrun, data_valid);
        end
        iop4 = 1'b0;
        wait_ticks(4);
        drain();
    endtask

    initial begin
        test_reset();
        test_iop1_skip();
        test_select_glitch();
        test_iop4_load();
        test_overrun();
        test_iop2_clear();
        test_iop1_noflag();
        test_iop2_vs_set();
        test_overlap();
        test_reset_mid_pulse();
        wait_ticks(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d words never delivered, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
